play_timer_ctrl: RTL and testbench

- Run/pause/done sequencer for the game's mm:ss play timer, driven by the top-level `choosing`, debounced `play` pulse and `isdone` signals.
- Generates the 1 s tick internally from `clk`; no separate derived clock.
- Maintains a BCD time count and a best-completion-time record.
- Feeds the 7-segment scan logic (BCD digits) and the screen/LED logic (state, flags).

---
 rtl/play_timer_ctrl.sv | 139 +++++++++++++
 tb/tb_play_timer_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/play_timer_ctrl.sv
// play_timer_ctrl: run/pause/done sequencer for the mm:ss play timer.
// Derives the 1 s tick from clk, keeps a saturating BCD time count and
// records the best (lowest) completion time across runs.
module play_timer_ctrl #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        choosing,
    input  logic        play_pulse,
    input  logic        isdone,
    output logic [1:0]  state,
    output logic        running,
    output logic        sec_tick,
    output logic        done_pulse,
    output logic [15:0] time_bcd,
    output logic        ovf,
    output logic [15:0] best_bcd,
    output logic        best_valid
);

    localparam logic [1:0] ST_SETUP = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    state_nxt;
    logic          tick;
    logic          enter_done;
    logic          at_max;
    logic [3:0]    s1, s10, m1, m10;
    logic [3:0]    n_s1, n_s10, n_m1, n_m10;

    assign s1  = time_bcd[3:0];
    assign s10 = time_bcd[7:4];
    assign m1  = time_bcd[11:8];
    assign m10 = time_bcd[15:12];
    assign at_max = (time_bcd == 16'h9959);

    // Next-state selection with choosing > isdone > play_pulse priority
    always_comb begin
        state_nxt  = state;
        enter_done = 1'b0;
        if (choosing) begin
            state_nxt = ST_SETUP;
        end else begin
            case (state)
                ST_SETUP: state_nxt = ST_RUN;
                ST_RUN: begin
                    if (isdone) begin
                        state_nxt  = ST_DONE;
                        enter_done = 1'b1;
                    end else if (play_pulse) begin
                        state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (isdone) begin
                        state_nxt  = ST_DONE;
                        enter_done = 1'b1;
                    end else if (play_pulse) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_DONE;
            endcase
        end
        tick = (state == ST_RUN) && (presc == PRESC_MAX) && !choosing && !isdone;
    end

    // BCD ripple increment of the time count (used only when not saturated)
    always_comb begin
        n_s1  = s1;
        n_s10 = s10;
        n_m1  = m1;
        n_m10 = m10;
        if (s1 != 4'd9) begin
            n_s1 = s1 + 4'd1;
        end else begin
            n_s1 = 4'd0;
            if (s10 != 4'd5) begin
                n_s10 = s10 + 4'd1;
            end else begin
                n_s10 = 4'd0;
                if (m1 != 4'd9) begin
                    n_m1 = m1 + 4'd1;
                end else begin
                    n_m1  = 4'd0;
                    n_m10 = m10 + 4'd1;
                end
            end
        end
    end

    // State, prescaler, time count, flags and best-time record
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_SETUP;
            running    <= 1'b0;
            presc      <= '0;
            time_bcd   <= '0;
            ovf        <= 1'b0;
            sec_tick   <= 1'b0;
            done_pulse <= 1'b0;
            best_bcd   <= '0;
            best_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            running    <= (state_nxt == ST_RUN);
            sec_tick   <= tick;
            done_pulse <= enter_done;
            if (choosing) begin
                presc    <= '0;
                time_bcd <= '0;
                ovf      <= 1'b0;
            end else begin
                if (tick) begin
                    presc <= '0;
                    if (at_max) begin
                        ovf <= 1'b1;
                    end else begin
                        time_bcd <= {n_m10, n_m1, n_s10, n_s1};
                    end
                end else if (state == ST_RUN && !isdone) begin
                    presc <= presc + 1'b1;
                end
                if (enter_done && (!best_valid || time_bcd < best_bcd)) begin
                    best_bcd   <= time_bcd;
                    best_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_play_timer_ctrl.sv
// Directed bench for play_timer_ctrl with TICK_DIV=4.
module tb_play_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        choosing;
    logic        play_pulse;
    logic        isdone;
    logic [1:0]  state;
    logic        running;
    logic        sec_tick;
    logic        done_pulse;
    logic [15:0] time_bcd;
    logic        ovf;
    logic [15:0] best_bcd;
    logic        best_valid;

    int unsigned total = 0;
    int unsigned bad   = 0;

    play_timer_ctrl #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .choosing   (choosing),
        .play_pulse (play_pulse),
        .isdone     (isdone),
        .state      (state),
        .running    (running),
        .sec_tick   (sec_tick),
        .done_pulse (done_pulse),
        .time_bcd   (time_bcd),
        .ovf        (ovf),
        .best_bcd   (best_bcd),
        .best_valid (best_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; choosing = 1'b0; play_pulse = 1'b0; isdone = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'h0);
        check("rst_time", 32'(time_bcd), 32'h0);
        check("rst_valid", 32'(best_valid), 32'h0);
        check("rst_tick", 32'(sec_tick), 32'h0);
        step(2);
        rst = 1'b0;

        // auto-start from SETUP, tick every 4 cycles
        step(1);
        check("autostart_state", 32'(state), 32'h1);
        check("autostart_running", 32'(running), 32'h1);
        step(3);
        check("no_tick_yet", 32'(sec_tick), 32'h0);
        step(1);
        check("first_tick", 32'(sec_tick), 32'h1);
        check("time_0001", 32'(time_bcd), 32'h0001);
        step(1);
        check("tick_one_cycle", 32'(sec_tick), 32'h0);
        step(35);
        check("time_0010", 32'(time_bcd), 32'h0010);
        step(196);
        check("time_0059", 32'(time_bcd), 32'h0059);
        step(4);
        check("time_0100", 32'(time_bcd), 32'h0100);

        // long run to saturation
        step(23756);
        check("time_9959", 32'(time_bcd), 32'h9959);
        check("ovf_before", 32'(ovf), 32'h0);
        step(4);
        check("sat_time", 32'(time_bcd), 32'h9959);
        check("ovf_set", 32'(ovf), 32'h1);
        step(8);
        check("ovf_sticky", 32'(ovf), 32'h1);

        // choosing clears time and ovf
        choosing = 1'b1;
        step(1);
        choosing = 1'b0;
        check("choose_state", 32'(state), 32'h0);
        check("choose_time", 32'(time_bcd), 32'h0);
        check("choose_ovf", 32'(ovf), 32'h0);
        step(1);
        check("rerun_state", 32'(state), 32'h1);

        // pause with prescaler at 2, hold, resume
        step(2);
        play_pulse = 1'b1;
        step(1);
        play_pulse = 1'b0;
        check("pause_state", 32'(state), 32'h2);
        check("pause_running", 32'(running), 32'h0);
        step(20);
        check("pause_hold_time", 32'(time_bcd), 32'h0);
        check("pause_hold_state", 32'(state), 32'h2);
        play_pulse = 1'b1;
        step(1);
        play_pulse = 1'b0;
        check("resume_state", 32'(state), 32'h1);
        check("resume_no_tick", 32'(sec_tick), 32'h0);
        step(1);
        check("resume_tick", 32'(sec_tick), 32'h1);
        check("resume_time", 32'(time_bcd), 32'h0001);

        // finish at 00:07 with simultaneous play_pulse
        step(24);
        check("pre_done_time", 32'(time_bcd), 32'h0007);
        isdone = 1'b1; play_pulse = 1'b1;
        step(1);
        play_pulse = 1'b0;
        check("done_state", 32'(state), 32'h3);
        check("done_pulse", 32'(done_pulse), 32'h1);
        check("best_0007", 32'(best_bcd), 32'h0007);
        check("best_valid", 32'(best_valid), 32'h1);
        step(1);
        check("done_pulse_once", 32'(done_pulse), 32'h0);
        step(3);
        isdone = 1'b0;
        check("held_isdone_no_pulse", 32'(done_pulse), 32'h0);
        for (int i = 0; i < 3; i++) begin
            play_pulse = 1'b1;
            step(1);
            play_pulse = 1'b0;
            step(2);
        end
        check("done_ignores_play", 32'(state), 32'h3);
        check("done_time_hold", 32'(time_bcd), 32'h0007);

        // second run finishes faster at 00:05
        choosing = 1'b1;
        step(1);
        choosing = 1'b0;
        check("best_kept_choose", 32'(best_bcd), 32'h0007);
        step(21);
        check("run2_time", 32'(time_bcd), 32'h0005);
        isdone = 1'b1;
        step(1);
        isdone = 1'b0;
        check("best_0005", 32'(best_bcd), 32'h0005);

        // third run slower at 00:09: record stays
        choosing = 1'b1;
        step(1);
        choosing = 1'b0;
        step(37);
        check("run3_time", 32'(time_bcd), 32'h0009);
        isdone = 1'b1;
        step(1);
        isdone = 1'b0;
        check("run3_done_pulse", 32'(done_pulse), 32'h1);
        check("best_stays_0005", 32'(best_bcd), 32'h0005);

        // choosing mid-PAUSE
        choosing = 1'b1;
        step(1);
        choosing = 1'b0;
        step(5);
        play_pulse = 1'b1;
        step(1);
        play_pulse = 1'b0;
        check("pause2_state", 32'(state), 32'h2);
        check("pause2_time", 32'(time_bcd), 32'h0001);
        choosing = 1'b1;
        step(1);
        check("choose_pause_time", 32'(time_bcd), 32'h0);
        check("choose_pause_state", 32'(state), 32'h0);
        check("choose_pause_best", 32'(best_bcd), 32'h0005);
        choosing = 1'b0;

        // async reset between edges mid-RUN
        step(6);
        check("prerst_state", 32'(state), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'h0);
        check("arst_running", 32'(running), 32'h0);
        check("arst_time", 32'(time_bcd), 32'h0);
        check("arst_best", 32'(best_bcd), 32'h0);
        check("arst_valid", 32'(best_valid), 32'h0);
        check("arst_ovf", 32'(ovf), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
